// File: rtl/press_decoder_pkg.sv
// press_decoder_pkg
// Shared definitions for the button press decoder: event type codes,
// FSM state encoding and default timing constants for a 12 MHz hwclk.
package press_decoder_pkg;

    localparam logic [1:0] EVT_DIGIT = 2'b00;
    localparam logic [1:0] EVT_LONG  = 2'b01;
    localparam logic [1:0] EVT_OVF   = 2'b10;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESSED  = 3'd1,
        GAP      = 3'd2,
        HOLD     = 3'd3,
        WAIT_REL = 3'd4
    } state_t;

    localparam int unsigned DEF_DEBOUNCE_TICKS = 120000;    // 10 ms
    localparam int unsigned DEF_LONG_TICKS     = 12000000;  // 1 s
    localparam int unsigned DEF_GAP_TICKS      = 9000000;   // 0.75 s
    localparam logic [3:0]  DEF_MAX_PRESSES    = 4'd9;
    localparam int          DEF_CNT_W          = 32;

    // Press count saturates at 15 so a long burst can never wrap back
    // into the legal digit range.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/press_decoder_btn_debounce.sv
// btn_debounce
// Two-flop synchronizer followed by a stability counter.
// Ports:
//   hwclk  in   system clock
//   rst    in   synchronous active-high reset
//   din    in   asynchronous raw input
//   level  out  debounced level
//   rise   out  one-cycle pulse in the cycle before level goes 0->1
//   fall   out  one-cycle pulse in the cycle before level goes 1->0
// rise/fall are combinational look-ahead pulses, so a consumer that
// registers on them lines up with the first cycle of the new level.
module btn_debounce
    import press_decoder_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS
) (
    input  logic hwclk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_TICKS + 1);

    logic            sync_a;
    logic            sync_b;
    logic [DB_W-1:0] db_cnt;
    logic            flip;

    always_ff @(posedge hwclk) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= din;
            sync_b <= sync_a;
        end
    end

    // The DEBOUNCE_TICKS-th consecutive disagreeing cycle flips the level.
    assign flip = (sync_b != level) && (db_cnt == DB_W'(DEBOUNCE_TICKS - 1));

    always_ff @(posedge hwclk) begin
        if (rst) begin
            level  <= 1'b0;
            db_cnt <= '0;
        end else if (sync_b == level) begin
            db_cnt <= '0;
        end else if (flip) begin
            level  <= ~level;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign rise = flip & ~level;
    assign fall = flip &  level;

endmodule

// File: rtl/press_decoder.sv
// press_decoder
// Turns debounced button activity into lock-entry events: a run of short
// presses closed by an idle gap becomes a DIGIT, a long press becomes
// LONG, and too many short presses become OVERFLOW. Events are held on a
// valid/ack handshake.
// Ports:
//   hwclk      in   system clock (12 MHz)
//   rst        in   synchronous active-high reset
//   btn_raw    in   asynchronous button pin, high = pressed
//   evt_valid  out  event available, held until acknowledged
//   evt_type   out  00 DIGIT, 01 LONG, 10 OVERFLOW
//   evt_digit  out  press count for DIGIT, 0 otherwise
//   evt_ack    in   accepts the event when high while evt_valid=1
//   press_led  out  debounced button level
//   busy       out  high whenever the FSM is not IDLE
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for the first press of a sequence
// PRESSED  | button down, measuring press duration
// GAP      | button up after a short press, measuring the idle gap
// HOLD     | event presented, waiting for evt_ack
// WAIT_REL | event accepted while button still down, waiting for release
module press_decoder
    import press_decoder_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
    parameter int unsigned LONG_TICKS     = DEF_LONG_TICKS,
    parameter int unsigned GAP_TICKS      = DEF_GAP_TICKS,
    parameter logic [3:0]  MAX_PRESSES    = DEF_MAX_PRESSES,
    parameter int          CNT_W          = DEF_CNT_W
) (
    input  logic       hwclk,
    input  logic       rst,
    input  logic       btn_raw,
    output logic       evt_valid,
    output logic [1:0] evt_type,
    output logic [3:0] evt_digit,
    input  logic       evt_ack,
    output logic       press_led,
    output logic       busy
);

    localparam logic [CNT_W-1:0] LONG_C   = CNT_W'(LONG_TICKS);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_TICKS - 1);

    logic             level;
    logic             rise;
    logic             fall;
    state_t           state;
    state_t           state_nx;
    logic             emit;
    logic [1:0]       emit_type;
    logic [CNT_W-1:0] dur;
    logic [CNT_W-1:0] gap;
    logic [3:0]       cnt;
    logic [1:0]       evt_type_r;
    logic [3:0]       evt_digit_r;

    btn_debounce #(
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_debounce (
        .hwclk (hwclk),
        .rst   (rst),
        .din   (btn_raw),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    always_ff @(posedge hwclk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        emit      = 1'b0;
        emit_type = EVT_DIGIT;
        case (state)
            IDLE: begin
                if (rise) state_nx = PRESSED;
            end
            PRESSED: begin
                if (fall) begin
                    if (dur < LONG_C) begin
                        state_nx = GAP;
                    end else begin
                        emit      = 1'b1;
                        emit_type = EVT_LONG;
                    end
                end
            end
            GAP: begin
                // A new press wins over gap expiry in the same cycle.
                if (rise) begin
                    state_nx = PRESSED;
                end else if (gap == GAP_LAST) begin
                    emit      = 1'b1;
                    emit_type = (cnt > MAX_PRESSES) ? EVT_OVF : EVT_DIGIT;
                end
            end
            HOLD: begin
                if (evt_ack) state_nx = level ? WAIT_REL : IDLE;
            end
            WAIT_REL: begin
                if (fall) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (emit) state_nx = HOLD;
    end

    always_ff @(posedge hwclk) begin
        if (rst) begin
            dur         <= '0;
            gap         <= '0;
            cnt         <= '0;
            evt_type_r  <= EVT_DIGIT;
            evt_digit_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) dur <= '0;
                end
                PRESSED: begin
                    if (fall && (dur < LONG_C)) begin
                        cnt <= sat_inc4(cnt);
                        gap <= '0;
                    end else if (dur != LONG_C) begin
                        dur <= dur + 1'b1;
                    end
                end
                GAP: begin
                    if (rise) dur <= '0;
                    else      gap <= gap + 1'b1;
                end
                default: ;
            endcase
            // Every emit path clears the count, including LONG.
            if (emit) begin
                evt_type_r  <= emit_type;
                evt_digit_r <= (emit_type == EVT_DIGIT) ? cnt : 4'd0;
                cnt         <= '0;
            end
        end
    end

    always_comb begin
        evt_valid = 1'b0;
        evt_type  = EVT_DIGIT;
        evt_digit = 4'd0;
        busy      = (state != IDLE);
        if (state == HOLD) begin
            evt_valid = 1'b1;
            evt_type  = evt_type_r;
            evt_digit = evt_digit_r;
        end
    end

    assign press_led = level;

endmodule

// File: doc/press_decoder.md
Name: press_decoder

Overview:
- Decodes timed button presses into lock-entry events; it is the input-side counterpart of the LED blink generator.
- Debounces a raw push-button and counts short presses. An idle gap closes the count and presents it as a digit.
- A long press is reported as a command event.
- Sits between the board button pin and the lock controller. Events are handed off with a valid/ack handshake.

Parameters:
- DEBOUNCE_TICKS, 120000, cycles the synchronized input must be stable before the debounced level changes (10 ms at 12 MHz)
- LONG_TICKS, 12000000, debounced-high duration at or above which a press is long (1 s)
- GAP_TICKS, 9000000, debounced-low duration after a short press that closes a digit (0.75 s)
- MAX_PRESSES, 4'd9, highest legal digit; more presses give an OVERFLOW event
- CNT_W, 32, width of the duration counters

Ports:
- hwclk  in  1  system clock, 12 MHz
- rst  in  1  synchronous, active-high reset
- btn_raw  in  1  asynchronous button pin, high = pressed
- evt_valid  out  1  event available; held until accepted
- evt_type  out  2  00 DIGIT, 01 LONG, 10 OVERFLOW, 11 unused
- evt_digit  out  4  short-press count for DIGIT; 0 otherwise
- evt_ack  in  1  controller accepts the event when sampled high while evt_valid=1
- press_led  out  1  debounced button level, for user feedback
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, hwclk. Reset is synchronous and active-high (rst). Reset has priority over all other activity, including mid-press and mid-handshake.
- Reset values: evt_valid=0, evt_type=00, evt_digit=0, press_led=0, busy=0. All counters and the press count are 0. State is IDLE. The debounced level is 0.
- Input path:
  - btn_raw passes through a 2-flop synchronizer.
  - The debouncer counts consecutive cycles where the synchronized value differs from the debounced level. When the count reaches DEBOUNCE_TICKS, the debounced level flips and the counter clears.
  - Any agreeing cycle clears the counter.
  - Latency from a clean edge to the debounced edge is 2+DEBOUNCE_TICKS cycles.
- The FSM acts only on debounced rise/fall pulses. Each pulse is one cycle wide.
- IDLE:
  - on rise: dur=0, go PRESSED.
- PRESSED:
  - dur increments each cycle, saturating at LONG_TICKS.
  - on fall with dur<LONG_TICKS: cnt=cnt+1 (saturating at 15), gap=0, go GAP.
  - on fall with dur>=LONG_TICKS: emit LONG and discard cnt.
- GAP:
  - gap increments each cycle.
  - a rise before gap reaches GAP_TICKS: dur=0, go PRESSED. cnt is kept.
  - when gap==GAP_TICKS-1: emit DIGIT if cnt<=MAX_PRESSES, otherwise emit OVERFLOW.
- Emit (all event types):
  - On the next cycle: evt_valid=1, type and digit registered, cnt=0, go HOLD.
  - evt_digit carries cnt for DIGIT. It is 0 for LONG and OVERFLOW.
- HOLD:
  - evt_valid, evt_type and evt_digit stay stable until evt_ack=1.
  - In the ack cycle evt_valid drops on the next edge.
  - If the debounced level is high at ack, go WAIT_REL; otherwise go IDLE.
  - Presses during HOLD are not counted.
- WAIT_REL:
  - on fall: go IDLE. No event is generated.
- evt_ack while evt_valid=0 is ignored.
- A press and release of zero debounced length is impossible by construction; no special case is needed.
- A long press always yields LONG, even after prior short presses in the same sequence.
- press_led is the debounced level, with no extra register stage.

Decomposition:
- Shared package holds:
  - event type constants: EVT_DIGIT=2'b00, EVT_LONG=2'b01, EVT_OVF=2'b10
  - FSM state encodings: IDLE, PRESSED, GAP, HOLD, WAIT_REL
  - default timing constants for 12 MHz
- One sub-module, btn_debounce:
  - contains the synchronizer and debounce counter
  - parameter DEBOUNCE_TICKS
  - ports: hwclk, rst, din, level, rise, fall

Test Plan:
All scenarios use DEBOUNCE_TICKS=4, LONG_TICKS=40, GAP_TICKS=30.
- Three clean presses, each 10 cycles high with 10-cycle gaps, then idle → exactly one evt_valid with type 00, digit 3, asserted 30 cycles after the last debounced fall. Hold ack low for 5 cycles → outputs stable throughout; ack → valid=0 next cycle, busy=0.
- Bounce: btn_raw toggles every 2 cycles for 20 cycles, then is held high for 15 and released → press_led rises once; a single DIGIT event with digit 1.
- Press held for 50 cycles, after two prior short presses → one LONG event with digit 0; the next sequence of one press gives digit 1, showing cnt was cleared.
- Ten short presses → OVERFLOW with digit 0. Sixteen short presses → OVERFLOW, with no count wrap.
- Button pressed during HOLD and still held at ack → goes to WAIT_REL; no event on release; the next single press gives DIGIT 1.
- rst asserted mid-PRESSED and again in HOLD → the next cycle shows all outputs at reset values and state IDLE; a subsequent press sequence decodes normally.
